mem_bridge: RTL

Synchronous memory bridge sitting directly downstream of the multicycle `cpu`. It turns the CPU's level-held `readM`/`writeM` strobes, address and write data into a registered req/ack handshake toward a variable-latency memory. It returns read data to the CPU together with a one-cycle `cpu_ready` completion pulse. The CPU-side tristate `data` bus is split outside this block into `cpu_wdata`/`cpu_rdata`.

---
 rtl/mem_bridge_pkg.sv | 17 +
 rtl/mem_bridge_timer.sv | 35 +++
 rtl/mem_bridge.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared types and constants for the CPU-to-memory bridge.
//   state_t       - bridge FSM state encoding (IDLE, REQ, DONE, HOLD)
//   DEF_WORD_SIZE - default address/data width
//   TIMEOUT_DATA  - read data returned to the CPU when the memory times out
package mem_bridge_pkg;

  localparam int unsigned DEF_WORD_SIZE = 16;
  localparam logic [15:0] TIMEOUT_DATA  = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/mem_bridge_timer.sv
// mem_bridge_timer: wait-cycle counter for the bridge's memory timeout.
//   clk, reset - clock, asynchronous active-high reset
//   load       - clear the counter (bridge not waiting on memory)
//   count      - one more cycle spent waiting with no ack
//   expire     - this counting cycle is the TIMEOUT-th consecutive wait
// Only instantiated when MEM_BRIDGE_TIMEOUT_EN is defined.
module mem_bridge_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic count,
  output logic expire
);

  localparam int unsigned CW = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + CW'(1);
    end
  end

  // cnt holds the number of wait cycles already elapsed, so the edge that
  // would make it TIMEOUT is the expiring one.
  assign expire = count && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bridge.sv
// mem_bridge: converts the multicycle CPU's level-held readM/writeM strobes
// into a registered req/ack handshake toward variable-latency memory, and
// returns read data with a one-cycle cpu_ready completion pulse.
//   CPU side : cpu_readM, cpu_writeM, cpu_address, cpu_wdata (in);
//              cpu_rdata, cpu_ready (out)
//   Mem side : mem_req, mem_we, mem_addr, mem_wdata (out);
//              mem_rdata, mem_ack (in)
//   Status   : access_count (completed accesses), proto_err (sticky, both
//              strobes seen together), err_timeout (sticky memory timeout)
// Optional feature macro: MEM_BRIDGE_TIMEOUT_EN enables the REQ wait timeout;
// without it REQ waits indefinitely and err_timeout stays 0.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int unsigned WORD_SIZE = DEF_WORD_SIZE,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_readM,
  input  logic                 cpu_writeM,
  input  logic [WORD_SIZE-1:0] cpu_address,
  input  logic [WORD_SIZE-1:0] cpu_wdata,
  output logic [WORD_SIZE-1:0] cpu_rdata,
  output logic                 cpu_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic [WORD_SIZE-1:0] access_count,
  output logic                 proto_err,
  output logic                 err_timeout
);

  state_t state;
  logic   cpu_strobe;
  logic   req_changed;

  assign cpu_strobe  = cpu_readM | cpu_writeM;
  // A held strobe only starts a new access if it names a different access.
  assign req_changed = (cpu_address != mem_addr) || (cpu_writeM != mem_we);

`ifdef MEM_BRIDGE_TIMEOUT_EN
  logic timer_expire;

  mem_bridge_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (state != REQ),
    .count  ((state == REQ) && !mem_ack),
    .expire (timer_expire)
  );
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cpu_rdata    <= '0;
      cpu_ready    <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      access_count <= '0;
      proto_err    <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cpu_ready <= 1'b0;
          if (cpu_strobe) begin
            mem_addr  <= cpu_address;
            mem_wdata <= cpu_wdata;
            mem_we    <= cpu_writeM;
            mem_req   <= 1'b1;
            if (cpu_readM && cpu_writeM) proto_err <= 1'b1;
            state     <= REQ;
          end
        end

        REQ: begin
          if (mem_ack) begin
            if (!mem_we) cpu_rdata <= mem_rdata;
            access_count <= access_count + WORD_SIZE'(1);
            mem_req      <= 1'b0;
            cpu_ready    <= 1'b1;
            state        <= DONE;
          end
`ifdef MEM_BRIDGE_TIMEOUT_EN
          else if (timer_expire) begin
            if (!mem_we) cpu_rdata <= WORD_SIZE'(TIMEOUT_DATA);
            err_timeout <= 1'b1;
            mem_req     <= 1'b0;
            cpu_ready   <= 1'b1;
            state       <= DONE;
          end
`endif
        end

        DONE: begin
          cpu_ready <= 1'b0;
          state     <= HOLD;
        end

        HOLD: begin
          cpu_ready <= 1'b0;
          if (!cpu_strobe) begin
            state <= IDLE;
          end else if (req_changed) begin
            // Back-to-back access straight from HOLD, skipping IDLE.
            mem_addr  <= cpu_address;
            mem_wdata <= cpu_wdata;
            mem_we    <= cpu_writeM;
            mem_req   <= 1'b1;
            if (cpu_readM && cpu_writeM) proto_err <= 1'b1;
            state     <= REQ;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
